video_timing_gen: RTL and testbench

Raster timing source for the 15 kHz low-resolution display path. It divides Clock_100Mhz down to a pixel clock and runs the horizontal and vertical beam counters. It decodes horizontal, vertical and composite sync plus blanking for the video DAC. It sits directly upstream of the game renderer, which consumes H_COUNTER/V_COUNTER and samples on the rising edge of PIXEL_CLOCK.

---
 rtl/video_timing_pkg.sv | 41 ++++
 rtl/video_timing_gen_pixel_clock_div.sv | 44 ++++
 rtl/video_timing_gen.sv | 101 ++++++++++
 tb/tb_video_timing_gen.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared raster timing constants, screen bounds and sync decode helper.
package video_timing_pkg;

  localparam int CNT_W = 9;

  localparam int CLK_DIV_DEF        = 16;
  localparam int H_TOTAL_DEF        = 400;
  localparam int H_SYNC_END_DEF     = 30;
  localparam int H_ACTIVE_START_DEF = 64;
  localparam int H_ACTIVE_END_DEF   = 392;
  localparam int V_TOTAL_DEF        = 262;
  localparam int V_SYNC_END_DEF     = 3;
  localparam int V_ACTIVE_START_DEF = 22;
  localparam int V_ACTIVE_END_DEF   = 262;

  // Visible window bounds (inclusive), shared with the renderer
  localparam int SCREEN_LEFT   = H_ACTIVE_START_DEF;
  localparam int SCREEN_RIGHT  = H_ACTIVE_END_DEF - 1;
  localparam int SCREEN_TOP    = V_ACTIVE_START_DEF;
  localparam int SCREEN_BOTTOM = V_ACTIVE_END_DEF - 1;

  typedef struct packed {
    logic h_sync;   // active low
    logic v_sync;   // active low
    logic c_sync;   // active low, serrated in vsync
    logic blank;    // 1 = visible
  } sync_t;

  localparam sync_t SYNC_RST = '{h_sync: 1'b1, v_sync: 1'b1, c_sync: 1'b1, blank: 1'b0};

  // Active-high hs/vs/visible -> DAC-facing sync levels
  function automatic sync_t decode_sync(input logic hs, input logic vs, input logic vis);
    sync_t s;
    s.h_sync = ~hs;
    s.v_sync = ~vs;
    s.c_sync = ~(hs ^ vs);
    s.blank  = vis;
    return s;
  endfunction

endpackage

// File: rtl/video_timing_gen_pixel_clock_div.sv
// Pixel clock divider: free-running count, 50% pixel clock and advance tick.
module pixel_clock_div #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  output logic pixel_clock,
  output logic pixel_tick,
  output logic advance
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
  // Count value one edge before the divider reaches CLK_DIV/2
  localparam logic [DW-1:0] D_HALF = DW'(CLK_DIV / 2 - 1);

  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
    $error("pixel_clock_div: CLK_DIV must be even and >= 2");
  end

  logic [DW-1:0] d;

  // High during the cycle whose closing edge wraps d to 0
  assign advance = (d == D_LAST);

  // Divider count, pixel clock phase and registered tick pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      d           <= '0;
      pixel_clock <= 1'b0;
      pixel_tick  <= 1'b0;
    end else begin
      pixel_tick <= advance;
      if (advance) begin
        d           <= '0;
        pixel_clock <= 1'b0;
      end else begin
        d <= d + 1'b1;
        if (d == D_HALF) pixel_clock <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing source: beam counters plus registered sync/blank decode.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int CLK_DIV        = CLK_DIV_DEF,
  parameter int H_TOTAL        = H_TOTAL_DEF,
  parameter int H_SYNC_END     = H_SYNC_END_DEF,
  parameter int H_ACTIVE_START = H_ACTIVE_START_DEF,
  parameter int H_ACTIVE_END   = H_ACTIVE_END_DEF,
  parameter int V_TOTAL        = V_TOTAL_DEF,
  parameter int V_SYNC_END     = V_SYNC_END_DEF,
  parameter int V_ACTIVE_START = V_ACTIVE_START_DEF,
  parameter int V_ACTIVE_END   = V_ACTIVE_END_DEF
) (
  input  logic             Clock_100Mhz,
  input  logic             Reset,
  output logic             PIXEL_CLOCK,
  output logic             PIXEL_TICK,
  output logic [CNT_W-1:0] H_COUNTER,
  output logic [CNT_W-1:0] V_COUNTER,
  output logic             H_SYNC,
  output logic             V_SYNC,
  output logic             C_SYNC,
  output logic             VGA_BLANK,
  output logic             FRAME_START
);

  if (H_TOTAL > 512 || V_TOTAL > 512) begin : g_bad_total
    $error("video_timing_gen: H_TOTAL and V_TOTAL must be <= 512");
  end

  // One extra bit so bounds like 512 still compare correctly
  localparam int CW = CNT_W + 1;
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SE   = CW'(H_SYNC_END);
  localparam logic [CW-1:0] V_SE   = CW'(V_SYNC_END);
  localparam logic [CW-1:0] H_AS   = CW'(H_ACTIVE_START);
  localparam logic [CW-1:0] H_AE   = CW'(H_ACTIVE_END);
  localparam logic [CW-1:0] V_AS   = CW'(V_ACTIVE_START);
  localparam logic [CW-1:0] V_AE   = CW'(V_ACTIVE_END);

  logic             advance;
  logic [CNT_W-1:0] h, v, h_nxt, v_nxt;
  logic [CW-1:0]    hx, vx;
  logic             hs, vs, vis, frame;
  sync_t            sync_q;

  pixel_clock_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk         (Clock_100Mhz),
    .rst         (Reset),
    .pixel_clock (PIXEL_CLOCK),
    .pixel_tick  (PIXEL_TICK),
    .advance     (advance)
  );

  // Next beam position; V steps only on the H wrap
  always_comb begin
    h_nxt = h;
    v_nxt = v;
    if (advance) begin
      if ({1'b0, h} == H_LAST) begin
        h_nxt = '0;
        v_nxt = ({1'b0, v} == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h_nxt = h + 1'b1;
      end
    end
  end

  // Decode from the next position so outputs move with the counters
  assign hx  = {1'b0, h_nxt};
  assign vx  = {1'b0, v_nxt};
  assign hs  = hx < H_SE;
  assign vs  = vx < V_SE;
  assign vis = (hx >= H_AS) && (hx < H_AE) && (vx >= V_AS) && (vx < V_AE);

  // Counter, decode and frame-start registers
  always_ff @(posedge Clock_100Mhz) begin
    if (Reset) begin
      h      <= '0;
      v      <= '0;
      sync_q <= SYNC_RST;
      frame  <= 1'b0;
    end else begin
      h     <= h_nxt;
      v     <= v_nxt;
      frame <= advance && (h_nxt == '0) && (v_nxt == '0);
      if (advance) sync_q <= decode_sync(hs, vs, vis);
    end
  end

  assign H_COUNTER   = h;
  assign V_COUNTER   = v;
  assign H_SYNC      = sync_q.h_sync;
  assign V_SYNC      = sync_q.v_sync;
  assign C_SYNC      = sync_q.c_sync;
  assign VGA_BLANK   = sync_q.blank;
  assign FRAME_START = frame;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a shrunken raster (80x10 lines, /16).
module tb_video_timing_gen;

  localparam int DIV = 16, HT = 80, VT = 10;
  localparam int LINE = DIV * HT, FRAME = LINE * VT;

  logic       clk = 1'b0, rst = 1'b1;
  logic       pclk, ptick, hsync, vsync, csync, blank, fstart;
  logic [8:0] hc, vc;

  int n_cmp = 0, n_bad = 0;

  video_timing_gen #(
    .CLK_DIV(DIV), .H_TOTAL(HT), .H_SYNC_END(30), .H_ACTIVE_START(64), .H_ACTIVE_END(78),
    .V_TOTAL(VT), .V_SYNC_END(3), .V_ACTIVE_START(5), .V_ACTIVE_END(10)
  ) dut (
    .Clock_100Mhz(clk), .Reset(rst), .PIXEL_CLOCK(pclk), .PIXEL_TICK(ptick),
    .H_COUNTER(hc), .V_COUNTER(vc), .H_SYNC(hsync), .V_SYNC(vsync), .C_SYNC(csync),
    .VGA_BLANK(blank), .FRAME_START(fstart)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n edges, sample 1 time unit after the last one
  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, " pclk"},  pclk,   0);
    chk({tag, " tick"},  ptick,  0);
    chk({tag, " H"},     hc,     0);
    chk({tag, " V"},     vc,     0);
    chk({tag, " d"},     dut.u_div.d, 0);
    chk({tag, " syncs"}, {hsync, vsync, csync}, 3'b111);
    chk({tag, " blank"}, blank,  0);
    chk({tag, " fs"},    fstart, 0);
  endtask

  int   h_at[FRAME];
  int   last_tick, tick_err, rise_err, c_err, n_ticks, n_rises;
  int   hs_low_l4, vs_low, blank_hi, pclk_hi, found;
  logic prev_pclk;
  logic b_70_7, b_63_7, b_64_5, b_77_9, b_78_9, b_70_4;

  initial begin
    {b_70_7, b_63_7, b_64_5, b_77_9, b_78_9, b_70_4} = 'x;

    // Reset held 20 cycles
    adv(10);
    chk_rst_vals("in_reset");
    adv(10);
    rst = 1'b0;

    // First tick 16 edges after release, H=1
    adv(15);
    chk("pre_tick tick", ptick, 0);
    chk("pre_tick H", hc, 0);
    chk("pre_tick hsync", hsync, 1);
    adv(1);
    chk("tick1 tick", ptick, 1);
    chk("tick1 H", hc, 1);
    chk("tick1 V", vc, 0);
    chk("tick1 syncs", {hsync, vsync, csync, blank, fstart}, 5'b00100);
    adv(1);
    chk("tick1+1 tick", ptick, 0);
    adv(6);
    chk("pclk +7", pclk, 0);
    adv(1);
    chk("pclk +8", pclk, 1);
    adv(8);
    chk("tick2 pclk", pclk, 0);
    chk("tick2 H", hc, 2);

    // Line and frame wraps at known tick indices
    adv(DIV * 77);
    chk("k79 HV", {hc, vc}, {9'd79, 9'd0});
    chk("k79 syncs", {hsync, vsync, csync, blank}, 4'b1000);
    adv(DIV);
    chk("k80 HV", {hc, vc}, {9'd0, 9'd1});
    chk("k80 syncs", {hsync, vsync, csync, fstart}, 4'b0010);
    adv(DIV * 719);
    chk("k799 HV", {hc, vc}, {9'd79, 9'd9});
    chk("k799 syncs", {hsync, vsync, csync, blank, fstart}, 5'b11100);
    adv(DIV);
    chk("k800 HV", {hc, vc}, {9'd0, 9'd0});
    chk("k800 fs", fstart, 1);
    chk("k800 tick", ptick, 1);

    // Scan one frame cycle by cycle, starting on the FRAME_START cycle
    last_tick = 0; tick_err = 0; rise_err = 0; c_err = 0; n_ticks = 0; n_rises = 0;
    hs_low_l4 = 0; vs_low = 0; blank_hi = 0; pclk_hi = 0; found = -1; prev_pclk = pclk;
    for (int i = 0; i < FRAME + 200; i++) begin
      if (i > 0) begin
        adv(1);
        if (fstart) begin found = i; break; end
      end
      if (i >= FRAME) continue;
      h_at[i] = int'(hc);
      if (ptick) begin
        if (i > 0 && i - last_tick != DIV) tick_err++;
        last_tick = i;
        n_ticks++;
      end
      if (pclk && !prev_pclk) begin
        n_rises++;
        if (i - last_tick != DIV / 2) rise_err++;
        if (i < 8 || h_at[i - 8] != int'(hc)) rise_err++;
      end
      prev_pclk = pclk;
      if (pclk) pclk_hi++;
      if (!hsync && vc == 4) hs_low_l4++;
      if (!vsync) vs_low++;
      if (blank) blank_hi++;
      if (csync !== (vsync ? hsync : ~hsync)) c_err++;
      if (hc == 70 && vc == 7) b_70_7 = blank;
      if (hc == 63 && vc == 7) b_63_7 = blank;
      if (hc == 64 && vc == 5) b_64_5 = blank;
      if (hc == 77 && vc == 9) b_77_9 = blank;
      if (hc == 78 && vc == 9) b_78_9 = blank;
      if (hc == 70 && vc == 4) b_70_4 = blank;
    end
    chk("frame period", found, FRAME);
    chk("fs width", fstart, 1);
    adv(1);
    chk("fs one cycle", fstart, 0);
    chk("tick count", n_ticks, HT * VT);
    chk("tick spacing err", tick_err, 0);
    chk("pclk rises", n_rises, HT * VT);
    chk("pclk rise err", rise_err, 0);
    chk("pclk high cycles", pclk_hi, FRAME / 2);
    chk("hsync low line4", hs_low_l4, 30 * DIV);
    chk("vsync low", vs_low, 3 * LINE);
    chk("csync err", c_err, 0);
    chk("blank high", blank_hi, 14 * 5 * DIV);
    chk("blank 70,7", b_70_7, 1);
    chk("blank 63,7", b_63_7, 0);
    chk("blank 64,5", b_64_5, 1);
    chk("blank 77,9", b_77_9, 1);
    chk("blank 78,9", b_78_9, 0);
    chk("blank 70,4", b_70_4, 0);

    // Reset mid-line at H=40, V=5
    found = 0;
    for (int i = 0; i < FRAME + 200; i++) begin
      if (hc == 40 && vc == 5) begin found = 1; break; end
      adv(1);
    end
    chk("reach 40,5", found, 1);
    rst = 1'b1;
    adv(1);
    chk_rst_vals("mid_reset");
    adv(3);
    chk("held reset fs", fstart, 0);
    chk("held reset H", hc, 0);
    rst = 1'b0;
    adv(DIV);
    chk("re tick", ptick, 1);
    chk("re H", hc, 1);
    chk("re fs", fstart, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
